// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared state encoding, init tables and delay helpers for the LCD nibble sequencer
package lcd_seq_pkg;
  typedef enum logic [2:0] {PWRUP, SETUP, EHIGH, HOLD, WAIT, IDLE} state_t;
  localparam logic [3:0] INIT_NIBBLE [0:3] = '{4'h3, 4'h3, 4'h3, 4'h2};
  localparam int INIT_WAIT_US [0:3] = '{4100, 100, 100, 100};
  function automatic int us_to_cyc(input int us, input int mhz);
    return us * mhz;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/lcd_nibble_sequencer_if.sv
// lcd_nibble_sequencer_if: postbox byte handshake between the receiver side and the LCD sequencer
interface lcd_nibble_sequencer_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master (output in_data, in_valid, input in_ready);
  modport slave (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter that saturates at zero and flags done while at zero
module lcd_delay_timer #(
  parameter int W = 18,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic refclk,
  input  logic reset,
  input  logic load,
  input  logic [W-1:0] value,
  output logic done
);
  logic [W-1:0] cnt;
  always_ff @(posedge refclk or posedge reset)
    if (reset) cnt <= RST_VAL;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/lcd_nibble_sequencer.sv
// lcd_nibble_sequencer: HD44780 4-bit init plus per-byte nibble write with setup/E/hold/busy timing
module lcd_nibble_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int CLK_MHZ = 12,
  parameter int SETUP_CYC = 2,
  parameter int E_CYC = 6,
  parameter int HOLD_CYC = 2,
  parameter int POWERUP_US = 15000,
  parameter int WAIT_CMD_US = 5000,
  parameter int WAIT_DATA_US = 50
) (
  input  logic refclk,
  input  logic reset,
  lcd_nibble_sequencer_if.slave pb,
  output logic [3:0] lcd_dq,
  output logic lcd_rs,
  output logic lcd_e,
  output logic init_done
);
  localparam int TW = clog2(us_to_cyc(POWERUP_US, CLK_MHZ) + 1);
  localparam logic [TW-1:0] PWR_LD = TW'(us_to_cyc(POWERUP_US, CLK_MHZ) - 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] E_LD = TW'(E_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] CMD_LD = TW'(us_to_cyc(WAIT_CMD_US, CLK_MHZ) - 1);
  localparam logic [TW-1:0] DATA_LD = TW'(us_to_cyc(WAIT_DATA_US, CLK_MHZ) - 1);
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [3:0] dq_n;
  logic rs_n, done_n, ld, t_done;
  logic [TW-1:0] ld_val, wait_ld;
  logic unused_bits;
  assign unused_bits = ^pb.in_data[2:1];
  assign wait_ld = init_done ? (lcd_rs ? DATA_LD : CMD_LD)
                             : TW'(us_to_cyc(INIT_WAIT_US[idx], CLK_MHZ) - 1);
  lcd_delay_timer #(.W(TW), .RST_VAL(PWR_LD)) u_timer (
    .refclk(refclk),
    .reset(reset),
    .load(ld),
    .value(ld_val),
    .done(t_done)
  );
  always_comb begin
    state_n = state;
    dq_n = lcd_dq;
    rs_n = lcd_rs;
    idx_n = idx;
    done_n = init_done;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      PWRUP: if (t_done) begin
        state_n = SETUP;
        dq_n = INIT_NIBBLE[0];
        rs_n = 1'b0;
        idx_n = '0;
        ld = 1'b1;
        ld_val = SETUP_LD;
      end
      SETUP: if (t_done) begin
        state_n = EHIGH;
        ld = 1'b1;
        ld_val = E_LD;
      end
      EHIGH: if (t_done) begin
        state_n = HOLD;
        ld = 1'b1;
        ld_val = HOLD_LD;
      end
      HOLD: if (t_done) begin
        state_n = WAIT;
        ld = 1'b1;
        ld_val = wait_ld;
      end
      WAIT: if (t_done) begin
        if (init_done || idx == 2'd3) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else begin
          state_n = SETUP;
          idx_n = idx + 2'd1;
          dq_n = INIT_NIBBLE[idx + 2'd1];
          ld = 1'b1;
          ld_val = SETUP_LD;
        end
      end
      IDLE: if (pb.in_valid) begin
        // a non-LCD byte parks in WAIT for one cycle so in_ready blinks low once
        ld = 1'b1;
        state_n = pb.in_data[0] ? WAIT : SETUP;
        ld_val = pb.in_data[0] ? '0 : SETUP_LD;
        dq_n = pb.in_data[0] ? lcd_dq : pb.in_data[7:4];
        rs_n = pb.in_data[0] ? lcd_rs : pb.in_data[3];
      end
      default: state_n = PWRUP;
    endcase
  end
  always_ff @(posedge refclk or posedge reset)
    if (reset) begin
      state <= PWRUP;
      idx <= '0;
      lcd_dq <= '0;
      lcd_rs <= 1'b0;
      lcd_e <= 1'b0;
      pb.in_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      lcd_dq <= dq_n;
      lcd_rs <= rs_n;
      lcd_e <= state_n == EHIGH;
      pb.in_ready <= state_n == IDLE;
      init_done <= done_n;
    end
endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// tb_lcd_nibble_sequencer: directed table-driven bench for the LCD nibble sequencer at CLK_MHZ=1
module tb_lcd_nibble_sequencer;
  localparam int SU = 2;
  localparam int EC = 6;
  localparam int HC = 2;
  localparam int PWR = 15000;
  typedef struct {
    logic [7:0] data;
    bit keep;
    int gap;
    logic [3:0] dq;
    logic rs;
    int pulses;
  } vec_t;
  typedef struct {
    int c;
    logic [3:0] dq;
    logic rs;
  } rise_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] lcd_dq;
  logic lcd_rs, lcd_e, init_done;
  int cyc;
  int total = 0;
  int bad = 0;
  rise_t rises[$];
  logic e_prev = 1'b0;
  logic [3:0] e_dq;
  logic e_rs;
  int e_len;
  bit e_stable;
  vec_t vecs[7];
  lcd_nibble_sequencer_if pb();
  lcd_nibble_sequencer #(.CLK_MHZ(1)) dut (
    .refclk(clk),
    .reset(rst),
    .pb(pb),
    .lcd_dq(lcd_dq),
    .lcd_rs(lcd_rs),
    .lcd_e(lcd_e),
    .init_done(init_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  // E window monitor: records every rising edge and checks width and dq/rs stability
  always @(posedge clk) begin
    #1;
    if (rst) e_prev = 1'b0;
    else begin
      if (lcd_e && !e_prev) begin
        rises.push_back('{cyc, lcd_dq, lcd_rs});
        e_dq = lcd_dq;
        e_rs = lcd_rs;
        e_len = 1;
        e_stable = 1'b1;
      end else if (lcd_e) begin
        e_len++;
        if (lcd_dq !== e_dq || lcd_rs !== e_rs) e_stable = 1'b0;
      end else if (e_prev) begin
        check("e_width", e_len, EC);
        check("e_stable", e_stable, 1);
      end
      e_prev = lcd_e;
    end
  end
  task automatic run_init();
    int exp_rise[4];
    int waits[4];
    int t;
    waits = '{4100, 100, 100, 100};
    t = PWR + SU;
    for (int i = 0; i < 4; i++) begin
      exp_rise[i] = t;
      t = t + EC + HC + waits[i] + SU;
    end
    rises.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30000 && !init_done; k++) begin
      @(posedge clk);
      #1;
    end
    check("init_done_cyc", cyc, exp_rise[3] + EC + HC + waits[3]);
    check("init_ready", pb.in_ready, 1);
    check("init_pulses", rises.size(), 4);
    for (int i = 0; i < 4 && i < rises.size(); i++) begin
      check("init_rise_cyc", rises[i].c, exp_rise[i]);
      check("init_dq", rises[i].dq, (i == 3) ? 2 : 3);
      check("init_rs", rises[i].rs, 0);
    end
  endtask
  task automatic apply(input vec_t v);
    int n;
    for (int k = 0; k < 6000 && !pb.in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    check("ready_before", pb.in_ready, 1);
    pb.in_data = v.data;
    pb.in_valid = 1'b1;
    rises.delete();
    @(posedge clk);
    #1;
    n = cyc;
    check("ready_drop", pb.in_ready, 0);
    for (int k = 0; k < 6000 && !pb.in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    check("ready_gap", cyc - n, v.gap);
    if (!v.keep) pb.in_valid = 1'b0;
    check("pulses", rises.size(), v.pulses);
    if (rises.size() > 0) begin
      check("e_rise_lat", rises[0].c - n, SU);
      check("e_dq", rises[0].dq, v.dq);
      check("e_rs", rises[0].rs, v.rs);
    end
    check("dq_end", lcd_dq, v.dq);
    check("rs_end", lcd_rs, v.rs);
  endtask
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{8'h48, 1'b0, 60, 4'h4, 1'b1, 1};
    vecs[1] = '{8'h10, 1'b1, 5010, 4'h1, 1'b0, 1};
    vecs[2] = '{8'h51, 1'b0, 1, 4'h1, 1'b0, 0};
    vecs[3] = '{8'hA8, 1'b1, 60, 4'hA, 1'b1, 1};
    vecs[4] = '{8'h59, 1'b1, 1, 4'hA, 1'b1, 0};
    vecs[5] = '{8'h3C, 1'b1, 60, 4'h3, 1'b1, 1};
    vecs[6] = '{8'hF8, 1'b0, 60, 4'hF, 1'b1, 1};
    pb.in_data = 8'h00;
    pb.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_e", lcd_e, 0);
    check("rst_dq", lcd_dq, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_ready", pb.in_ready, 0);
    check("rst_done", init_done, 0);
    run_init();
    for (int i = 0; i < 7; i++) apply(vecs[i]);
    // abort a write in the middle of its E pulse
    pb.in_data = 8'h48;
    pb.in_valid = 1'b1;
    @(posedge clk);
    #1;
    pb.in_valid = 1'b0;
    for (int k = 0; k < 10 && !lcd_e; k++) begin
      @(posedge clk);
      #1;
    end
    check("abort_e_high", lcd_e, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_e", lcd_e, 0);
    check("abort_dq", lcd_dq, 0);
    check("abort_rs", lcd_rs, 0);
    check("abort_ready", pb.in_ready, 0);
    check("abort_done", init_done, 0);
    repeat (3) @(posedge clk);
    run_init();
    apply('{8'h2A, 1'b0, 60, 4'h2, 1'b1, 1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
